flash_responder: RTL and testbench
==================================

# flash_responder

Synthesizable flash-device responder that sits on the device side of the flash memory controller's ce/oe/we/address/data interface. It holds a small 16-bit-wide array, answers controller read cycles with data after enforced access delays, and accepts we-strobed program cycles with flash semantics: bits can only be cleared. It replaces the off-chip flash in simulation and FPGA bring-up, and a direct preload port fills it with network weights or images.

## Interface
Parameters:
- ADDR_BITS, 8, array depth is 2^ADDR_BITS words of 16 bits
- T_ACC, 5, minimum consecutive clock edges with ce low before data is valid (1..15)
- T_OE, 3, minimum consecutive clock edges with ce and oe low before data is valid (1..15)

Ports:
- clk  input  1  clock
- n_rst  input  1  reset, asynchronous, active-low
- ce  input  1  chip enable, active-low
- oe  input  1  output enable, active-low
- we  input  1  write enable, active-low
- address  input  16  word address from the controller
- data_in  input  16  program data, sampled on the we rising edge
- prog_en  input  1  preload strobe, direct overwrite
- prog_addr  input  ADDR_BITS  preload address
- prog_data  input  16  preload data
- data_out  output  16  read data; 16'h0000 when not valid
- data_valid  output  1  data_out holds the array word for the latched address
- err  output  1  oe and we both low during a chip-enabled cycle

## Operation
- States: STANDBY, READ, WRITE, ERROR. The state register updates every edge from the sampled ce, oe, we, in this priority order:
  - ce=1 → STANDBY, from any state.
  - ce=0, we=0, oe=0 → ERROR. The block stays in ERROR until ce=1.
  - WRITE with we=1, which is the we rising edge → program the word, then go to READ.
  - ce=0, we=0, oe=1 → WRITE.
  - ce=0, we=1 → READ.
- Address latch addr_lat:
  - Loads address on every edge in STANDBY or READ.
  - Holds in WRITE and ERROR. The last load in WRITE is the edge that entered WRITE.
- acc_cnt, 4 bits, saturates at 15:
  - Increments on each edge where ce=0 and the state stays READ or WRITE.
  - Clears to 0 on an edge with ce=1.
  - Clears to 0 on a READ edge where address ≠ addr_lat. This re-arms the access time.
- oe_cnt, 4 bits, saturates at 15:
  - Increments on edges with ce=0 and oe=0 in READ.
  - Clears otherwise.
  - Also clears on an address change.
- Read output is combinational from registers:
  - data_valid = (state==READ) && acc_cnt≥T_ACC && oe_cnt≥T_OE.
  - data_out = data_valid ? word : 16'h0000.
  - word = mem[addr_lat] when address[15:ADDR_BITS]==0; otherwise 16'hFFFF.
- Program cycle:
  - On the WRITE→READ edge: mem[addr_lat] ← mem[addr_lat] & data_in.
  - If address[15:ADDR_BITS]≠0, the write is ignored.
  - acc_cnt and oe_cnt clear on this edge.
- Preload:
  - When prog_en=1 and ce=1 on an edge: mem[prog_addr] ← prog_data. This overwrites; it does not AND.
  - prog_en is ignored while ce=0.
- err = (state==ERROR). No array write occurs in ERROR.

## Timing
- Reset, asynchronous:
  - state=STANDBY, acc_cnt=0, oe_cnt=0, addr_lat=0.
  - Every array word = 16'hFFFF (erased).
  - Outputs: data_out=16'h0000, data_valid=0, err=0.
- Reset asserted mid-read:
  - data_valid drops to 0 immediately, without waiting for a clock.
  - Array contents return to 16'hFFFF.
- Read latency, with address stable and oe falling k edges after ce falls:
  - data_valid rises after max(T_ACC, k+T_OE) edges with ce sampled low.
  - With controller timing (oe low about 6 edges after ce, load about 5 edges later), data is valid before load.
- data_valid falls in the same cycle that the state leaves READ or a counter clears, i.e. one edge after the input change.
- Back-to-back reads with ce held low and a new address: the counters restart from the edge that sees the new address.
- Preload takes one edge per word. A preload and a read of the same word on the same edge cannot occur, because ce=1 blocks reads.

## Test plan
- Reset:
  - Pulse n_rst.
  - Required: data_out=0, data_valid=0, err=0.
  - Then read 0x0010 with ce and oe held low. Required: data_out=16'hFFFF after 5 edges.
- Preload then read:
  - Preload mem[0x22]=16'hBEEF.
  - Drive ce low at edge 0 and oe low at edge 6, with address=0x22.
  - Required: data_valid=0 through edge 8; data_valid=1 with data_out=16'hBEEF from edge 9.
- Address change mid-read:
  - While data_valid=1 at 0x22, change address to 0x23, which was preloaded as 16'h1234.
  - Required: data_valid=0 on the next edge.
  - Required: data_valid=1 with data_out=16'h1234 after 5 more edges (oe held low).
- Program:
  - Set mem[0x05]=16'hF0F0.
  - Run a write cycle with data_in=16'h3C3C: ce=0, we low for 2 edges, then we high.
  - Then read. Required: data_out=16'h3030, the AND result.
- Error:
  - With ce=0, drive oe=0 and we=0 together.
  - Required: err=1 and data_valid=0.
  - Required: err=0 on the edge after ce=1, and mem is unchanged.
- Out of range:
  - Read address 0x0100 with ADDR_BITS=8. Required: data_out=16'hFFFF.
  - Write 16'h0000 to address 0x0100. Required: mem[0x00] is unchanged.

Source files
------------

// File: rtl/flash_responder.sv
`default_nettype none
// ============================================================================
//  Module   : flash_responder
//  Brief    : Device-side flash model for the flash controller's ce/oe/we bus.
//             Holds a 16-bit word array, answers reads after the access
//             delays T_ACC and T_OE have elapsed, programs words by clearing
//             bits only, and accepts a direct preload port.
//  Revision : 1.0 - initial release
// ============================================================================
module flash_responder #(
    parameter int ADDR_BITS = 8,
    parameter int T_ACC     = 5,
    parameter int T_OE      = 3
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 ce,
    input  logic                 oe,
    input  logic                 we,
    input  logic [15:0]          address,
    input  logic [15:0]          data_in,
    input  logic                 prog_en,
    input  logic [ADDR_BITS-1:0] prog_addr,
    input  logic [15:0]          prog_data,
    output logic [15:0]          data_out,
    output logic                 data_valid,
    output logic                 err
);

    localparam int         c_DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] c_T_ACC = 4'(T_ACC);
    localparam logic [3:0] c_T_OE  = 4'(T_OE);

    typedef enum logic [1:0] {
        ST_STANDBY = 2'd0,
        ST_READ    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [15:0]           r_addr_lat;
    logic [3:0]            r_acc_cnt;
    logic [3:0]            r_oe_cnt;
    logic [3:0]            w_acc_nxt;
    logic [3:0]            w_oe_nxt;
    logic [15:0]           r_mem [0:c_DEPTH-1];

    logic                  w_in_range;
    logic                  w_addr_change;
    logic                  w_program;
    logic                  w_load_addr;
    logic [ADDR_BITS-1:0]  w_lat_idx;
    logic [15:0]           w_word;

    // Saturating 4-bit increment shared by both access counters.
    function automatic logic [3:0] f_sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    // Words above the array depth read as erased and cannot be programmed.
    assign w_in_range    = ((address >> ADDR_BITS) == 16'd0);
    assign w_lat_idx     = r_addr_lat[ADDR_BITS-1:0];
    // A new address seen while reading re-arms both access timers.
    assign w_addr_change = (r_state == ST_READ) && (address != r_addr_lat);
    // The we rising edge inside a write cycle commits the program operation.
    assign w_program     = (r_state == ST_WRITE) && !ce && we;
    assign w_load_addr   = (r_state == ST_STANDBY) || (r_state == ST_READ);

    // Next-state selection from the sampled strobes, highest priority first.
    always_comb begin
        w_state_nxt = r_state;
        if (ce) begin
            w_state_nxt = ST_STANDBY;
        end else if (!we && !oe) begin
            w_state_nxt = ST_ERROR;
        end else if (r_state == ST_ERROR) begin
            w_state_nxt = ST_ERROR;
        end else if ((r_state == ST_WRITE) && we) begin
            w_state_nxt = ST_READ;
        end else if (!we) begin
            w_state_nxt = ST_WRITE;
        end else begin
            w_state_nxt = ST_READ;
        end
    end

    // Access counters: advance while a cycle stays active, clear on any re-arm.
    always_comb begin
        w_acc_nxt = 4'd0;
        w_oe_nxt  = 4'd0;
        if (!ce && !w_addr_change && !w_program) begin
            if ((w_state_nxt == ST_READ) || (w_state_nxt == ST_WRITE)) begin
                w_acc_nxt = f_sat_inc(r_acc_cnt);
            end
            if (!oe && (w_state_nxt == ST_READ)) begin
                w_oe_nxt = f_sat_inc(r_oe_cnt);
            end
        end
    end

    // State, address latch and counters share one register stage.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_STANDBY;
            r_addr_lat <= 16'd0;
            r_acc_cnt  <= 4'd0;
            r_oe_cnt   <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc_cnt <= w_acc_nxt;
            r_oe_cnt  <= w_oe_nxt;
            if (w_load_addr) begin
                r_addr_lat <= address;
            end
        end
    end

    // Array: erased on reset, preload overwrites, program can only clear bits.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= 16'hFFFF;
            end
        end else if (prog_en && ce) begin
            r_mem[prog_addr] <= prog_data;
        end else if (w_program && w_in_range) begin
            r_mem[w_lat_idx] <= r_mem[w_lat_idx] & data_in;
        end
    end

    // Read path is purely combinational from registers so reset drops it at once.
    always_comb begin
        w_word     = w_in_range ? r_mem[w_lat_idx] : 16'hFFFF;
        data_valid = (r_state == ST_READ) && (r_acc_cnt >= c_T_ACC) &&
                     (r_oe_cnt >= c_T_OE);
        data_out   = data_valid ? w_word : 16'h0000;
        err        = (r_state == ST_ERROR);
    end

endmodule
`default_nettype wire

// File: tb/tb_flash_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flash_responder
//  Brief    : Self-checking bench for flash_responder. A word-array model plus
//             the access-latency rule max(T_ACC, k+T_OE) give every expected
//             value for directed and randomized read/program/preload cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flash_responder;

    localparam int AB = 8;
    localparam int TA = 5;
    localparam int TO = 3;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        ce, oe, we;
    logic [15:0] address, data_in;
    logic        prog_en;
    logic [AB-1:0] prog_addr;
    logic [15:0] prog_data;
    logic [15:0] data_out;
    logic        data_valid;
    logic        err;

    int checks   = 0;
    int failures = 0;
    logic [15:0] mdl [0:(1<<AB)-1];

    flash_responder #(.ADDR_BITS(AB), .T_ACC(TA), .T_OE(TO)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .ce         (ce),
        .oe         (oe),
        .we         (we),
        .address    (address),
        .data_in    (data_in),
        .prog_en    (prog_en),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .data_out   (data_out),
        .data_valid (data_valid),
        .err        (err)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Hard stop in case the run never reaches its summary.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] expect_word(input logic [15:0] a);
        if ((a >> AB) != 16'd0) return 16'hFFFF;
        return mdl[a[AB-1:0]];
    endfunction

    task automatic model_erase;
        for (int i = 0; i < (1 << AB); i++) mdl[i] = 16'hFFFF;
    endtask

    task automatic preload(input logic [AB-1:0] a, input logic [15:0] d);
        ce = 1'b1; oe = 1'b1; we = 1'b1;
        prog_en = 1'b1; prog_addr = a; prog_data = d;
        tick;
        prog_en = 1'b0;
        mdl[a] = d;
    endtask

    // Read with ce falling first and oe sampled low from edge k+1 onward.
    task automatic read_cycle(input logic [15:0] a, input int k, input string tag,
                              input bit hold);
        int lat;
        lat = (TA > k + TO) ? TA : k + TO;
        address = a; we = 1'b1; ce = 1'b0; oe = (k == 0) ? 1'b0 : 1'b1;
        for (int e = 1; e <= lat + 2; e++) begin
            if (e == k + 1) oe = 1'b0;
            tick;
            chk({tag, "_valid"}, {15'd0, data_valid}, (e >= lat) ? 16'd1 : 16'd0);
            chk({tag, "_data"}, data_out, (e >= lat) ? expect_word(a) : 16'h0000);
        end
        if (!hold) begin
            ce = 1'b1; oe = 1'b1;
            tick;
            chk({tag, "_end_valid"}, {15'd0, data_valid}, 16'd0);
        end
    endtask

    // Program cycle: we low for nlow edges, then the we rising edge commits.
    task automatic write_cycle(input logic [15:0] a, input logic [15:0] d, input int nlow,
                               input string tag);
        ce = 1'b0; oe = 1'b1; we = 1'b0; address = a; data_in = d;
        for (int e = 0; e < nlow; e++) begin
            tick;
            chk({tag, "_err"}, {15'd0, err}, 16'd0);
            chk({tag, "_valid"}, {15'd0, data_valid}, 16'd0);
        end
        we = 1'b1;
        tick;
        chk({tag, "_commit_valid"}, {15'd0, data_valid}, 16'd0);
        ce = 1'b1;
        tick;
        if ((a >> AB) == 16'd0) mdl[a[AB-1:0]] = mdl[a[AB-1:0]] & d;
    endtask

    initial begin
        logic [15:0] ra, rd;
        int          op;
        ce = 1'b1; oe = 1'b1; we = 1'b1; address = 16'd0; data_in = 16'd0;
        prog_en = 1'b0; prog_addr = '0; prog_data = 16'd0;
        model_erase();

        // Reset values while n_rst is held low.
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", data_out, 16'h0000);
        chk("rst_valid", {15'd0, data_valid}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        n_rst = 1'b1;
        tick;
        read_cycle(16'h0010, 0, "rst_read", 1'b0);

        // Preload then read with oe falling six edges after ce.
        preload(8'h22, 16'hBEEF);
        preload(8'h23, 16'h1234);
        read_cycle(16'h0022, 6, "pre_read", 1'b1);

        // Address change while valid: drop next edge, valid again 5 edges later.
        address = 16'h0023;
        tick;
        chk("achg_drop", {15'd0, data_valid}, 16'd0);
        for (int e = 1; e <= 5; e++) begin
            tick;
            chk("achg_valid", {15'd0, data_valid}, (e == 5) ? 16'd1 : 16'd0);
            chk("achg_data", data_out, (e == 5) ? expect_word(16'h0023) : 16'h0000);
        end
        ce = 1'b1; oe = 1'b1;
        tick;
        chk("achg_end", {15'd0, data_valid}, 16'd0);

        // Program clears bits only.
        preload(8'h05, 16'hF0F0);
        write_cycle(16'h0005, 16'h3C3C, 2, "prog");
        read_cycle(16'h0005, 6, "prog_read", 1'b0);

        // Error: oe and we low together, held until ce rises, no array write.
        ce = 1'b0; oe = 1'b0; we = 1'b0; address = 16'h0005; data_in = 16'h0000;
        tick;
        chk("err_set", {15'd0, err}, 16'd1);
        chk("err_valid", {15'd0, data_valid}, 16'd0);
        tick;
        chk("err_hold", {15'd0, err}, 16'd1);
        oe = 1'b1; we = 1'b1;
        tick;
        chk("err_sticky", {15'd0, err}, 16'd1);
        chk("err_sticky_valid", {15'd0, data_valid}, 16'd0);
        ce = 1'b1;
        tick;
        chk("err_clear", {15'd0, err}, 16'd0);
        read_cycle(16'h0005, 2, "err_mem", 1'b0);

        // Out-of-range read returns erased; out-of-range write is dropped.
        preload(8'h00, 16'h5A5A);
        read_cycle(16'h0100, 3, "oor_read", 1'b0);
        write_cycle(16'h0100, 16'h0000, 2, "oor_wr");
        read_cycle(16'h0000, 4, "oor_mem", 1'b0);

        // Preload is ignored while ce is low.
        ce = 1'b0; oe = 1'b1; we = 1'b1; address = 16'h0040;
        prog_en = 1'b1; prog_addr = 8'h40; prog_data = 16'h0000;
        tick;
        prog_en = 1'b0; ce = 1'b1;
        tick;
        read_cycle(16'h0040, 1, "pe_block", 1'b0);

        // Randomized mix of preloads, program cycles and reads.
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 2);
            ra = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) ra = ra | 16'h0300;
            rd = 16'($urandom);
            case (op)
                0: preload(ra[AB-1:0], rd);
                1: write_cycle(ra, rd, $urandom_range(1, 3), "rnd_wr");
                default: read_cycle(ra, $urandom_range(0, 8), "rnd_rd", 1'b0);
            endcase
        end

        // Reset mid-read: valid drops without a clock, array returns to erased.
        preload(8'h30, 16'hA5A5);
        read_cycle(16'h0030, 2, "mid_rd", 1'b1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_valid", {15'd0, data_valid}, 16'd0);
        chk("mid_rst_data", data_out, 16'h0000);
        ce = 1'b1; oe = 1'b1;
        tick;
        n_rst = 1'b1;
        model_erase();
        tick;
        read_cycle(16'h0030, 0, "post_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
